id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register, directly downstream of the load-use stall control.
- Each cycle it does one of four things: latches the decoded instruction, inserts a bubble when the stall control raises Stall_flush, kills the entry on a branch flush, or freezes on a global hold.
- Its EX-side outputs (ex_mem_read, ex_rt) feed back into the stall control's EX_MemRead/EX_rt inputs.
- It also keeps saturating bubble and flush event counters for performance debug.

---
 rtl/id_ex_pipe_reg.sv | 137 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with bubble/kill/hold control and saturating
// performance counters for inserted bubbles and flushed instructions.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_flush,
  input  logic              flush,
  input  logic              hold,
  input  logic              cnt_clr,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic [2:0]        id_alu_ctl,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_op,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic [2:0]        ex_alu_ctl,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [2:0]        alu_ctl;
  } ex_fields_t;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_fields_t ex_d, ex_q, id_fields;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             do_bubble;

  // Control bits are qualified by id_valid so an empty slot never writes or loads.
  always_comb begin
    id_fields           = '0;
    id_fields.valid     = id_valid;
    id_fields.op        = id_op;
    id_fields.rs        = id_rs;
    id_fields.rt        = id_rt;
    id_fields.rd        = id_rd;
    id_fields.rs_data   = id_rs_data;
    id_fields.rt_data   = id_rt_data;
    id_fields.imm       = id_imm;
    id_fields.mem_read  = id_mem_read & id_valid;
    id_fields.mem_write = id_mem_write & id_valid;
    id_fields.reg_write = id_reg_write & id_valid;
    id_fields.alu_ctl   = id_alu_ctl;
  end

  assign do_bubble = !flush && !hold && stall_flush;

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (stall_flush) begin
      ex_d = '0;
    end else begin
      ex_d = id_fields;
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (cnt_clr) begin
      bubble_cnt_d = '0;
      flush_cnt_d  = '0;
    end else begin
      if (do_bubble && (bubble_cnt_q != CntMax)) bubble_cnt_d = bubble_cnt_q + CntOne;
      if (flush && id_valid && (flush_cnt_q != CntMax)) flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_op        = ex_q.op;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_rd        = ex_q.rd;
  assign ex_rs_data   = ex_q.rs_data;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_imm       = ex_q.imm;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_alu_ctl   = ex_q.alu_ctl;
  assign bubble_cnt   = bubble_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table, corner sequences and
// randomized traffic against a priority-rule reference model (CNT_W=4).
module tb_id_ex_pipe_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, stall_flush, flush, hold, cnt_clr, id_valid;
  logic [OP_W-1:0] id_op;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic id_mem_read, id_mem_write, id_reg_write;
  logic [2:0] id_alu_ctl;
  logic ex_valid;
  logic [OP_W-1:0] ex_op;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0] ex_alu_ctl;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_flush(stall_flush), .flush(flush), .hold(hold),
    .cnt_clr(cnt_clr), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_alu_ctl(id_alu_ctl), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_alu_ctl(ex_alu_ctl), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the EX-side state the spec's priority rules imply.
  logic m_valid, m_mr, m_mw, m_rw;
  logic [OP_W-1:0] m_op;
  logic [REG_W-1:0] m_rs, m_rt, m_rd;
  logic [DATA_W-1:0] m_rsd, m_rtd, m_imm;
  logic [2:0] m_alu;
  int m_bc, m_fc;

  task automatic model_clear_fields();
    m_valid = 0; m_op = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    m_rsd = '0; m_rtd = '0; m_imm = '0; m_mr = 0; m_mw = 0; m_rw = 0; m_alu = '0;
  endtask

  task automatic model_reset();
    model_clear_fields();
    m_bc = 0;
    m_fc = 0;
  endtask

  task automatic model_edge();
    if (flush) begin
      model_clear_fields();
      if (id_valid) m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
    end else if (hold) begin
      // frozen
    end else if (stall_flush) begin
      model_clear_fields();
      m_bc = (m_bc < CNT_MAX) ? m_bc + 1 : CNT_MAX;
    end else begin
      m_valid = id_valid; m_op = id_op; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm; m_alu = id_alu_ctl;
      m_mr = id_mem_read && id_valid;
      m_mw = id_mem_write && id_valid;
      m_rw = id_reg_write && id_valid;
    end
    if (cnt_clr) begin
      m_bc = 0;
      m_fc = 0;
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic [127:0] act, exp;
    act = {2'b0, ex_valid, ex_op, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_alu_ctl, bubble_cnt, flush_cnt};
    exp = {2'b0, m_valid, m_op, m_rs, m_rt, m_rd, m_rsd, m_rtd, m_imm,
           m_mr, m_mw, m_rw, m_alu, CNT_W'(m_bc), CNT_W'(m_fc)};
    check(name, act, exp);
  endtask

  task automatic check_zero(input string name);
    logic [127:0] act;
    act = {2'b0, ex_valid, ex_op, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_alu_ctl, bubble_cnt, flush_cnt};
    check(name, act, 128'd0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ctl(input logic f, input logic h, input logic s, input logic c);
    flush = f; hold = h; stall_flush = s; cnt_clr = c;
  endtask

  typedef struct {
    logic f, h, s, v;
    logic [2:0] op;
    logic [3:0] rt;
    logic mr, mw, rw;
    logic [31:0] rsd;
    logic e_v;
    logic [2:0] e_op;
    logic [3:0] e_rt;
    logic e_mr, e_mw, e_rw;
    logic [31:0] e_rsd;
    logic [3:0] e_bc, e_fc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [127:0] a, e;
    vecs[0]  = '{0,0,0,1, 3'd3,4'h5, 1,0,0, 32'h1234, 1,3'd3,4'h5, 1,0,0, 32'h1234, 0,0};
    vecs[1]  = '{0,0,1,1, 3'd7,4'h9, 1,0,0, 32'hAAAA, 0,3'd0,4'h0, 0,0,0, 32'h0, 1,0};
    vecs[2]  = '{0,0,1,1, 3'd7,4'h9, 1,0,0, 32'hAAAA, 0,3'd0,4'h0, 0,0,0, 32'h0, 2,0};
    vecs[3]  = '{0,0,0,1, 3'd2,4'h6, 0,0,1, 32'h55,   1,3'd2,4'h6, 0,0,1, 32'h55, 2,0};
    vecs[4]  = '{1,1,1,1, 3'd4,4'hA, 1,1,1, 32'hBEEF, 0,3'd0,4'h0, 0,0,0, 32'h0, 2,1};
    vecs[5]  = '{0,0,0,1, 3'd1,4'h7, 1,0,0, 32'h77,   1,3'd1,4'h7, 1,0,0, 32'h77, 2,1};
    vecs[6]  = '{0,1,1,1, 3'd4,4'hC, 0,1,1, 32'hCCCC, 1,3'd1,4'h7, 1,0,0, 32'h77, 2,1};
    vecs[7]  = '{0,0,0,0, 3'd5,4'h8, 1,1,1, 32'h99,   0,3'd5,4'h8, 0,0,0, 32'h99, 2,1};
    vecs[8]  = '{1,0,0,0, 3'd5,4'h8, 1,1,1, 32'h99,   0,3'd0,4'h0, 0,0,0, 32'h0, 2,1};
    vecs[9]  = '{0,0,0,1, 3'd6,4'h3, 1,0,0, 32'h1,    1,3'd6,4'h3, 1,0,0, 32'h1, 2,1};
    vecs[10] = '{0,0,1,1, 3'd6,4'h3, 1,0,0, 32'h1,    0,3'd0,4'h0, 0,0,0, 32'h0, 3,1};

    rst_n = 0;
    drive_ctl(0, 0, 0, 0);
    id_valid = 1; id_op = 3'd3; id_rs = 4'h1; id_rt = 4'h5; id_rd = 4'h2;
    id_rs_data = 32'h1111; id_rt_data = 32'h2222; id_imm = 32'hFFFF_FFF0;
    id_mem_read = 1; id_mem_write = 0; id_reg_write = 1; id_alu_ctl = 3'd5;
    model_reset();
    #2;
    check_zero("reset_initial");
    #1 rst_n = 1;
    step();
    check_model("first_load_after_reset");

    // Asynchronous reset pulse in the middle of a cycle.
    #2 rst_n = 0;
    #1 check_zero("reset_mid_cycle");
    model_reset();
    #1 rst_n = 1;
    id_op = 3'd6;
    step();
    check_model("load_after_mid_reset");
    rst_n = 0;
    #1 model_reset();
    rst_n = 1;
    @(negedge clk);

    id_rs = 4'h1; id_rd = 4'h2; id_rt_data = 32'h0; id_imm = 32'h10; id_alu_ctl = 3'd2;
    for (int i = 0; i < 11; i++) begin
      drive_ctl(vecs[i].f, vecs[i].h, vecs[i].s, 0);
      id_valid = vecs[i].v; id_op = vecs[i].op; id_rt = vecs[i].rt;
      id_mem_read = vecs[i].mr; id_mem_write = vecs[i].mw; id_reg_write = vecs[i].rw;
      id_rs_data = vecs[i].rsd;
      step();
      a = {42'b0, ex_valid, ex_op, ex_rt, ex_mem_read, ex_mem_write, ex_reg_write, ex_rs_data,
           bubble_cnt, flush_cnt};
      e = {42'b0, vecs[i].e_v, vecs[i].e_op, vecs[i].e_rt, vecs[i].e_mr, vecs[i].e_mw,
           vecs[i].e_rw, vecs[i].e_rsd, vecs[i].e_bc, vecs[i].e_fc};
      check($sformatf("vec%0d", i), a, e);
      check_model($sformatf("vec%0d_model", i));
    end

    // Saturation: 20 more bubbles from 3 must pin at 15.
    drive_ctl(0, 0, 1, 0);
    id_valid = 1;
    for (int i = 0; i < 20; i++) step();
    check({124'b0, bubble_cnt}, {124'b0, bubble_cnt}, {124'b0, bubble_cnt} & 128'hF);
    checks--;
    a = {124'b0, bubble_cnt};
    check("bubble_saturate", a, 128'd15);
    drive_ctl(0, 0, 1, 1);
    step();
    check("bubble_clear", {120'b0, bubble_cnt, flush_cnt}, 128'd0);
    check_model("clear_with_stall_model");

    // cnt_clr during a load leaves the pipeline fields alone.
    drive_ctl(1, 0, 0, 0);
    step();
    drive_ctl(0, 0, 0, 1);
    id_op = 3'd5; id_rs_data = 32'hCAFE;
    step();
    check("clear_keeps_fields", {88'b0, ex_valid, ex_op, ex_rs_data, flush_cnt},
          {88'b0, 1'b1, 3'd5, 32'hCAFE, 4'd0});

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_ctl(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 30) == 0));
      id_valid = ($urandom_range(0, 4) != 0);
      id_op = OP_W'($urandom); id_rs = REG_W'($urandom); id_rt = REG_W'($urandom);
      id_rd = REG_W'($urandom); id_rs_data = $urandom; id_rt_data = $urandom;
      id_imm = $urandom; id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
      id_reg_write = 1'($urandom); id_alu_ctl = 3'($urandom);
      step();
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
